// File: rtl/gpr_bank.sv
// -----------------------------------------------------------------------------
// gpr_bank
//   General-purpose register bank: 2^ADDR_W registers of DATA_W bits with two
//   combinational read ports, one synchronous write port, a flag register
//   aliased at index FLAG_ADDR, and a multi-cycle bank-clear sequencer.
//
//   Register 0 is hard-wired to zero. FLAG_ADDR must be nonzero and < DEPTH.
//
//   Optional feature macro: GPR_BYPASS_EN
//     Defined   -> pending writes / flag sets are forwarded onto the read
//                  ports in the same cycle (nflag beats din).
//     Undefined -> reads return stored contents only.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   we        in   write enable for awr/din
//   flag_op   in   2'b00 DIS, 2'b01 SET, 2'b10 SET_AND_WR, 2'b11 DIS
//   a1, a2    in   read addresses
//   awr       in   write address
//   din       in   write data
//   nflag     in   new flag value
//   clr_req   in   request to zero the whole bank
//   rd1, rd2  out  regs[a1], regs[a2] (combinational)
//   flag      out  regs[FLAG_ADDR] (combinational)
//   busy      out  clear sequence in progress
//   clr_done  out  one-cycle pulse when the clear sequence finishes
// -----------------------------------------------------------------------------
module gpr_bank #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FLAG_ADDR = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        flag_op,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] awr,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] nflag,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] flag,
    output logic              busy,
    output logic              clr_done
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(FLAG_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] regs_r [DEPTH];

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic              busy_r, busy_s;
    logic              clr_done_r, clr_done_s;
    logic              armed_r, armed_s;

    logic              clearing_s;
    logic              write_en_s;
    logic              flag_set_s;

    // Write / flag-set qualifiers; every port command is ignored while clearing.
    always_comb begin
        clearing_s = (state_r == ST_CLEAR);
        write_en_s = !clearing_s && we && (awr != '0) && (flag_op != 2'b01);
        flag_set_s = !clearing_s && ((flag_op == 2'b01) || (flag_op == 2'b10));
    end

    // Read mux shared by all three read outputs; address 0 always reads zero.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_r[addr];
        if (addr == '0) begin
            val = '0;
`ifdef GPR_BYPASS_EN
        end else if (!reset && flag_set_s && (addr == FLAG_IDX)) begin
            // Flag set wins over a colliding ordinary write, as in storage.
            val = nflag;
        end else if (!reset && write_en_s && (addr == awr)) begin
            val = din;
`endif
        end else begin
            val = regs_r[addr];
        end
        return val;
    endfunction

    // Combinational read ports.
    always_comb begin
        rd1  = read_port(a1);
        rd2  = read_port(a2);
        flag = read_port(FLAG_IDX);
    end

    // Register storage: clear sequencer, ordinary write, then flag set (last wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (clearing_s) begin
            regs_r[cnt_r] <= '0;
        end else begin
            if (write_en_s) begin
                regs_r[awr] <= din;
            end
            if (flag_set_s) begin
                regs_r[FLAG_IDX] <= nflag;
            end
        end
    end

    // Clear sequencer next-state logic. armed_r blocks a held clr_req from
    // starting a second sequence until it has been seen low in IDLE.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        busy_s     = 1'b0;
        clr_done_s = 1'b0;
        armed_s    = armed_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req && armed_r) begin
                    state_s = ST_CLEAR;
                    cnt_s   = ONE_IDX;
                    busy_s  = 1'b1;
                    armed_s = 1'b0;
                end else begin
                    armed_s = armed_r | ~clr_req;
                end
            end
            ST_CLEAR: begin
                // Terminates on the last index so the counter never wraps to 0.
                if (cnt_r == LAST_IDX) begin
                    state_s    = ST_IDLE;
                    cnt_s      = ONE_IDX;
                    clr_done_s = 1'b1;
                end else begin
                    cnt_s  = cnt_r + ONE_IDX;
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ONE_IDX;
            end
        endcase
    end

    // Clear sequencer state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= ONE_IDX;
            busy_r     <= 1'b0;
            clr_done_r <= 1'b0;
            armed_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            clr_done_r <= clr_done_s;
            armed_r    <= armed_s;
        end
    end

    assign busy     = busy_r;
    assign clr_done = clr_done_r;

endmodule

// File: tb/tb_gpr_bank.sv
// -----------------------------------------------------------------------------
// tb_gpr_bank
//   Directed self-checking bench for gpr_bank at default parameters.
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_gpr_bank;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  flag_op;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  awr;
    logic [31:0] din;
    logic [31:0] nflag;
    logic        clr_req;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] flag;
    logic        busy;
    logic        clr_done;

    int checks;
    int passes;

    gpr_bank dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .flag_op  (flag_op),
        .a1       (a1),
        .a2       (a2),
        .awr      (awr),
        .din      (din),
        .nflag    (nflag),
        .clr_req  (clr_req),
        .rd1      (rd1),
        .rd2      (rd2),
        .flag     (flag),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        flag_op = 2'b00;
        awr     = 5'd0;
        din     = 32'h0;
        nflag   = 32'h0;
        clr_req = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 1; i < 32; i++) begin
            we  = 1'b1;
            awr = 5'(i);
            din = 32'h1000_0000 + 32'(i);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            checks++;
            if (rd1 !== 32'h0) $display("FAIL reset_rd1[%0d] got=%h exp=0", i, rd1);
            else passes++;
            checks++;
            if (rd2 !== 32'h0) $display("FAIL reset_rd2[%0d] got=%h exp=0", 31 - i, rd2);
            else passes++;
        end
        checks++;
        if (flag !== 32'h0) $display("FAIL reset_flag got=%h exp=0", flag);
        else passes++;
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0)
            $display("FAIL reset_busy got=%b/%b exp=0/0", busy, clr_done);
        else passes++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        we = 1'b1; awr = 5'd20; din = 32'hFEDC1234;
        tick();
        we = 1'b0; a1 = 5'd20; a2 = 5'd20; din = 32'h01234567;
        #1;
        checks++;
        if (rd1 !== 32'hFEDC1234) $display("FAIL write_rd1 got=%h exp=FEDC1234", rd1);
        else passes++;
        tick();
        checks++;
        if (rd1 !== 32'hFEDC1234) $display("FAIL write_we0 got=%h exp=FEDC1234", rd1);
        else passes++;
        we = 1'b1; awr = 5'd0; din = 32'hFFFFFFFF;
        tick();
        we = 1'b0; a1 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'h0) $display("FAIL write_r0 got=%h exp=0", rd1);
        else passes++;
        checks++;
        if (rd2 !== 32'hFEDC1234) $display("FAIL write_rd2 got=%h exp=FEDC1234", rd2);
        else passes++;
    endtask

    task automatic test_flag();
        flag_op = 2'b01; nflag = 32'h1234CDEF;
        tick();
        flag_op = 2'b00; nflag = 32'h01234567;
        checks++;
        if (flag !== 32'h1234CDEF) $display("FAIL flag_set got=%h exp=1234CDEF", flag);
        else passes++;
        tick();
        checks++;
        if (flag !== 32'h1234CDEF) $display("FAIL flag_dis got=%h exp=1234CDEF", flag);
        else passes++;
        flag_op = 2'b11; nflag = 32'h0BADF00D;
        tick();
        checks++;
        if (flag !== 32'h1234CDEF) $display("FAIL flag_op11 got=%h exp=1234CDEF", flag);
        else passes++;
        flag_op = 2'b10; we = 1'b1; awr = 5'd21; din = 32'h98765432; nflag = 32'h12123434;
        tick();
        idle_inputs();
        a1 = 5'd21;
        #1;
        checks++;
        if (rd1 !== 32'h98765432) $display("FAIL setwr_reg got=%h exp=98765432", rd1);
        else passes++;
        checks++;
        if (flag !== 32'h12123434) $display("FAIL setwr_flag got=%h exp=12123434", flag);
        else passes++;
    endtask

    task automatic test_collision();
        flag_op = 2'b10; we = 1'b1; awr = 5'd30; din = 32'hAAAA0000; nflag = 32'h5555FFFF;
        tick();
        idle_inputs();
        a1 = 5'd30;
        #1;
        checks++;
        if (flag !== 32'h5555FFFF) $display("FAIL collide_flag got=%h exp=5555FFFF", flag);
        else passes++;
        checks++;
        if (rd1 !== 32'h5555FFFF) $display("FAIL collide_rd1 got=%h exp=5555FFFF", rd1);
        else passes++;
        we = 1'b1; awr = 5'd30; din = 32'h13579BDF;
        tick();
        idle_inputs();
        checks++;
        if (flag !== 32'h13579BDF) $display("FAIL dis_write_flag got=%h exp=13579BDF", flag);
        else passes++;
    endtask

    task automatic test_clear();
        int busy_cycles;
        int done_cycles;
        load_all();
        a1 = 5'd15;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        // Commands during busy must be ignored.
        we = 1'b1; awr = 5'd3; din = 32'hDEADBEEF;
        flag_op = 2'b01; nflag = 32'hFFFF0000;
        busy_cycles = 0;
        done_cycles = 0;
        if (busy === 1'b1) busy_cycles++;
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            if (clr_done === 1'b1) done_cycles++;
            if (k == 14) begin
                checks++;
                if (rd1 !== 32'h1000000F) $display("FAIL clr_partial14 got=%h exp=1000000F", rd1);
                else passes++;
            end
            if (k == 15) begin
                checks++;
                if (rd1 !== 32'h0) $display("FAIL clr_partial15 got=%h exp=0", rd1);
                else passes++;
            end
        end
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b1)
            $display("FAIL clr_end got busy/done=%b/%b exp=0/1", busy, clr_done);
        else passes++;
        tick();
        if (clr_done === 1'b1) done_cycles++;
        checks++;
        if (busy_cycles != 31) $display("FAIL clr_busy_len got=%0d exp=31", busy_cycles);
        else passes++;
        checks++;
        if (done_cycles != 1) $display("FAIL clr_done_len got=%0d exp=1", done_cycles);
        else passes++;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            #1;
            checks++;
            if (rd1 !== 32'h0) $display("FAIL clr_all[%0d] got=%h exp=0", i, rd1);
            else passes++;
        end
        checks++;
        if (flag !== 32'h0) $display("FAIL clr_flag got=%h exp=0", flag);
        else passes++;
    endtask

    task automatic test_clear_hold();
        int busy_cycles;
        clr_req = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 31) $display("FAIL hold_single_seq got=%0d exp=31", busy_cycles);
        else passes++;
        clr_req = 1'b0;
        tick();
        clr_req = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL hold_rearm got=%b exp=1", busy);
        else passes++;
        clr_req = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int done_cycles;
        load_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL midclr_busy got=%b exp=1", busy);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0)
            $display("FAIL midclr_reset got busy/done=%b/%b exp=0/0", busy, clr_done);
        else passes++;
        tick();
        reset = 1'b0;
        done_cycles = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (clr_done === 1'b1 || busy === 1'b1) done_cycles++;
        end
        checks++;
        if (done_cycles != 0) $display("FAIL midclr_no_done got=%0d exp=0", done_cycles);
        else passes++;
    endtask

    task automatic test_bypass();
        logic [31:0] exp_rd1;
        logic [31:0] exp_flag;
        we = 1'b1; awr = 5'd7; din = 32'h11111111;
        tick();
        din = 32'hCAFEBABE; a1 = 5'd7;
        #1;
`ifdef GPR_BYPASS_EN
        exp_rd1 = 32'hCAFEBABE;
`else
        exp_rd1 = 32'h11111111;
`endif
        checks++;
        if (rd1 !== exp_rd1) $display("FAIL bypass_rd1 got=%h exp=%h", rd1, exp_rd1);
        else passes++;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'hCAFEBABE) $display("FAIL bypass_after got=%h exp=CAFEBABE", rd1);
        else passes++;
        flag_op = 2'b01; nflag = 32'h77770000;
        #1;
`ifdef GPR_BYPASS_EN
        exp_flag = 32'h77770000;
`else
        exp_flag = 32'h0;
`endif
        checks++;
        if (flag !== exp_flag) $display("FAIL bypass_flag got=%h exp=%h", flag, exp_flag);
        else passes++;
        tick();
        idle_inputs();
        checks++;
        if (flag !== 32'h77770000) $display("FAIL bypass_flag_after got=%h exp=77770000", flag);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        a1 = 5'd0;
        a2 = 5'd0;
        test_reset();
        test_write();
        test_flag();
        test_collision();
        test_clear();
        test_clear_hold();
        test_reset_mid_clear();
        test_bypass();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
- Parametrised successor to the CPU general-purpose register file: 2^ADDR_W registers of DATA_W bits.
- Two async read ports, one sync write port, and a dedicated flag register mapped into the bank.
- Adds a multi-cycle bank-clear sequencer with busy/done handshake.
- Sits in the decode/writeback stage; flag output feeds branch/compare logic.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2^ADDR_W registers
FLAG_ADDR, 30, register index aliased as flag register; must be nonzero and < DEPTH

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
we  input  1  write enable for awr/din
flag_op  input  2  00 DIS, 01 SET, 10 SET_AND_WR, 11 treated as DIS
a1  input  ADDR_W  read address, port 1
a2  input  ADDR_W  read address, port 2
awr  input  ADDR_W  write address
din  input  DATA_W  write data
nflag  input  DATA_W  new flag value
clr_req  input  1  request to zero whole bank (sampled at clk edge)
rd1  output  DATA_W  regs[a1], combinational
rd2  output  DATA_W  regs[a2], combinational
flag  output  DATA_W  regs[FLAG_ADDR], combinational
busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse at end of clear

Behaviour:
- Interface fixed: one clock `clk`; `reset` asynchronous, active-high.
- Reset: all registers 0; busy=0, clr_done=0; FSM=IDLE, counter=1. Outputs read 0 while reset is high.
- Register 0 reads 0 always; any write to address 0 is dropped.
- Normal write (busy=0): at posedge, if we=1 and awr!=0, regs[awr]<=din. New value visible on rd1/rd2 after the edge (see optional feature).
- flag_op=SET: regs[FLAG_ADDR]<=nflag, independent of we.
- flag_op=SET_AND_WR: flag set as SET, plus normal write if we=1.
- Collision: flag set and we with awr==FLAG_ADDR in same cycle -> nflag wins.
- flag_op=DIS with we=1, awr==FLAG_ADDR: din written to flag (ordinary register).
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 at edge -> CLEAR, busy=1 from next cycle, counter=1.
  - CLEAR: each edge zeroes regs[counter], counter++. After clearing DEPTH-1 -> IDLE, busy=0, clr_done=1 for exactly one cycle. Sequence length is DEPTH-1 cycles (31 at defaults).
  - While busy: we, flag_op, clr_req ignored; reads still return current contents, partially cleared.
  - clr_req held high through completion: one sequence only; re-arms only after clr_req is seen low in IDLE.
  - Reset mid-clear: immediate return to IDLE, busy=0, no clr_done pulse.
- Counter wrap: counter is ADDR_W bits; termination is detected at DEPTH-1, never wraps to 0.

Optional Feature:
- Macro GPR_BYPASS_EN. When defined: if we=1, busy=0, awr!=0 and a1 (or a2) == awr, rd1 (rd2) returns din combinationally in the same cycle. A pending flag set likewise bypasses nflag onto flag and onto reads of FLAG_ADDR, with nflag taking priority.
- When undefined: reads return stored contents only; updated values appear after the edge.

Test Plan:
- Assert reset, sweep a1/a2 over 0..31 -> all rd1/rd2 = 0, flag = 0, busy = 0.
- we=1, awr=20, din=FEDC1234; next cycle a1=20 -> rd1=FEDC1234. we=0, din=01234567 -> rd1 stays FEDC1234. we=1, awr=0 -> rd1(a1=0)=0.
- flag_op=SET, nflag=1234CDEF -> flag=1234CDEF. flag_op=DIS, nflag=01234567 -> unchanged. SET_AND_WR, we=1, awr=21, din=98765432, nflag=12123434 -> regs[21]=98765432, flag=12123434.
- Collision: SET_AND_WR, we=1, awr=30, din=AAAA0000, nflag=5555FFFF -> flag=5555FFFF.
- Load regs 1..31 with nonzero values; pulse clr_req -> busy high 31 cycles; a1=15 reads 0 after the 15th cleared edge; we=1 during busy has no effect; clr_done high exactly 1 cycle; all regs 0. Repeat with reset at cycle 10 -> busy=0 at once, no clr_done.
- GPR_BYPASS_EN defined: we=1, awr=7, din=CAFEBABE, a1=7 -> rd1=CAFEBABE in the same cycle. Undefined: rd1 shows the old value until after the edge.
